// File: rtl/chunk_burster.sv
// chunk_burster: FIFO (ports in_valid/in_data/in_ready, out_valid/out_data/out_last/out_ready, flush, count) emitting CHUNK-word bursts, flush drains a partial chunk; CHUNK_BURSTER_STATS_EN adds chunks_sent/partial_sent
module chunk_burster #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  parameter int CHUNK = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  input  logic [WIDTH-1:0]       in_data,
  output logic                   in_ready,
  input  logic                   flush,
  output logic                   out_valid,
  output logic [WIDTH-1:0]       out_data,
  output logic                   out_last,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] count
`ifdef CHUNK_BURSTER_STATS_EN
  ,
  output logic [15:0]            chunks_sent,
  output logic [15:0]            partial_sent
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] CHUNK_C = CW'(CHUNK);
  typedef enum logic {IDLE, BURST} state_t;
  state_t state;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] beat, burst_len;
  logic flush_pending, push, pop, done;
  assign in_ready = !rst_n || count != DEPTH_C;
  assign out_valid = rst_n && state == BURST;
  assign out_last = out_valid && beat == burst_len - CW'(1);
  assign out_data = mem[rd_ptr];
  assign push = in_valid && in_ready;
  assign pop = out_valid && out_ready;
  assign done = pop && out_last;
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= in_data;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      state <= IDLE;
      beat <= '0;
      burst_len <= '0;
      flush_pending <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_ptr + AW'(pop);
      count <= count + CW'(push) - CW'(pop);
      if (state == IDLE) begin
        if (count >= CHUNK_C) begin
          state <= BURST;
          burst_len <= CHUNK_C;
        end else if (flush_pending && count != '0) begin
          state <= BURST;
          burst_len <= count;
        end
        flush_pending <= flush || (flush_pending && count != '0);
      end else begin
        beat <= done ? '0 : beat + CW'(pop);
        if (done) state <= IDLE;
        flush_pending <= flush || (flush_pending && !(done && burst_len < CHUNK_C));
      end
    end
  end
`ifdef CHUNK_BURSTER_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      chunks_sent <= '0;
      partial_sent <= '0;
    end else if (done) begin
      chunks_sent <= chunks_sent + 16'(chunks_sent != '1);
      partial_sent <= partial_sent + 16'(burst_len < CHUNK_C && partial_sent != '1);
    end
  end
`endif
endmodule

// File: tb/tb_chunk_burster.sv
// tb_chunk_burster: table-driven and directed checks of chunk_burster bursts, flush, backpressure and reset
module tb_chunk_burster;
  logic clk, rst_n, in_valid, flush, in_ready, out_valid, out_last, out_ready;
  logic [31:0] in_data, out_data;
  logic [4:0] count;
  int total = 0, bad = 0;
  typedef struct {
    logic iv;
    logic [31:0] d;
    logic fl;
    logic e_ov;
    logic e_ol;
    logic [31:0] e_data;
    logic [4:0] e_cnt;
  } vec_t;
  vec_t tbl[$];
  logic [31:0] q_data[$];
  logic q_last[$];
  logic s_ir, s_ov, s_ol, prev_stall, prev_last, acc;
  logic [4:0] s_cnt;
  logic [31:0] prev_data;

  chunk_burster dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .flush(flush), .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .out_ready(out_ready), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(logic iv, logic [31:0] d, logic fl, logic ov, logic ol, logic [31:0] ed, logic [4:0] ec);
    vec_t v;
    v.iv = iv; v.d = d; v.fl = fl; v.e_ov = ov; v.e_ol = ol; v.e_data = ed; v.e_cnt = ec;
    return v;
  endfunction

  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %h want %h", n, a, e);
    end
  endtask

  task automatic cycle();
    #1;
    s_ir = in_ready; s_ov = out_valid; s_ol = out_last; s_cnt = count;
    if (prev_stall) begin
      chk("stall_valid", {31'b0, out_valid}, 32'h1);
      chk("stall_data", out_data, prev_data);
      chk("stall_last", {31'b0, out_last}, {31'b0, prev_last});
    end
    if (out_valid && out_ready) begin
      q_data.push_back(out_data);
      q_last.push_back(out_last);
    end
    prev_stall = out_valid && !out_ready;
    prev_data = out_data;
    prev_last = out_last;
    acc = in_valid && in_ready;
    @(posedge clk);
    @(negedge clk);
    if (acc) in_valid = 1'b0;
  endtask

  task automatic push_word(logic [31:0] d);
    in_data = d;
    in_valid = 1'b1;
    for (int k = 0; k < 50 && in_valid; k++) cycle();
    if (in_valid) begin
      chk("push_timeout", 32'h0, 32'h1);
      in_valid = 1'b0;
    end
  endtask

  task automatic expect_beats(string name, logic [31:0] base, int n, logic [31:0] mask);
    chk({name, "_n"}, q_data.size(), n);
    for (int i = 0; i < n && i < q_data.size(); i++) begin
      chk($sformatf("%s_data%0d", name, i), q_data[i], base + i);
      chk($sformatf("%s_last%0d", name, i), {31'b0, q_last[i]}, {31'b0, mask[i]});
    end
    q_data.delete();
    q_last.delete();
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    cycle();
    flush = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; flush = 1'b0; out_ready = 1'b1;
    prev_stall = 1'b0; prev_last = 1'b0; prev_data = '0;
    tbl.push_back(mk(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 5'd0));
    tbl.push_back(mk(1'b1, 32'h1, 1'b0, 1'b0, 1'b0, 32'h0, 5'd0));
    tbl.push_back(mk(1'b1, 32'h2, 1'b0, 1'b0, 1'b0, 32'h0, 5'd1));
    tbl.push_back(mk(1'b1, 32'h3, 1'b0, 1'b0, 1'b0, 32'h0, 5'd2));
    tbl.push_back(mk(1'b1, 32'h4, 1'b0, 1'b0, 1'b0, 32'h0, 5'd3));
    tbl.push_back(mk(1'b1, 32'h5, 1'b0, 1'b0, 1'b0, 32'h0, 5'd4));
    tbl.push_back(mk(1'b1, 32'h6, 1'b0, 1'b0, 1'b0, 32'h0, 5'd5));
    tbl.push_back(mk(1'b1, 32'h7, 1'b0, 1'b1, 1'b0, 32'h1, 5'd6));
    tbl.push_back(mk(1'b1, 32'h8, 1'b0, 1'b1, 1'b0, 32'h2, 5'd6));
    tbl.push_back(mk(1'b1, 32'h9, 1'b0, 1'b1, 1'b0, 32'h3, 5'd6));
    tbl.push_back(mk(1'b1, 32'hA, 1'b0, 1'b1, 1'b0, 32'h4, 5'd6));
    tbl.push_back(mk(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h5, 5'd6));
    tbl.push_back(mk(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 5'd5));
    tbl.push_back(mk(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h6, 5'd5));
    tbl.push_back(mk(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h7, 5'd4));
    tbl.push_back(mk(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h8, 5'd3));
    tbl.push_back(mk(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h9, 5'd2));
    tbl.push_back(mk(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'hA, 5'd1));
    tbl.push_back(mk(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 5'd0));
    tbl.push_back(mk(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 5'd0));
    tbl.push_back(mk(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 5'd0));

    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_in_ready", {31'b0, in_ready}, 32'h1);
    chk("rst_out_valid", {31'b0, out_valid}, 32'h0);
    chk("rst_out_last", {31'b0, out_last}, 32'h0);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      in_valid = tbl[i].iv; in_data = tbl[i].d; flush = tbl[i].fl;
      #1;
      chk($sformatf("row%0d_ir", i), {31'b0, in_ready}, 32'h1);
      chk($sformatf("row%0d_ov", i), {31'b0, out_valid}, {31'b0, tbl[i].e_ov});
      chk($sformatf("row%0d_ol", i), {31'b0, out_last}, {31'b0, tbl[i].e_ol});
      chk($sformatf("row%0d_cnt", i), {27'b0, count}, {27'b0, tbl[i].e_cnt});
      if (tbl[i].e_ov) chk($sformatf("row%0d_data", i), out_data, tbl[i].e_data);
      @(posedge clk);
      @(negedge clk);
    end
    in_valid = 1'b0; flush = 1'b0;

    for (int i = 0; i < 7; i++) push_word(32'h10 + i);
    pulse_flush();
    repeat (20) cycle();
    expect_beats("flush7", 32'h10, 7, 32'h50);
    chk("flush7_cnt", {27'b0, s_cnt}, 32'h0);
    push_word(32'h99);
    repeat (10) cycle();
    chk("pending_cleared_n", q_data.size(), 0);
    chk("pending_cleared_cnt", {27'b0, s_cnt}, 32'h1);
    pulse_flush();
    repeat (10) cycle();
    expect_beats("flush1", 32'h99, 1, 32'h1);

    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) push_word(32'h30 + i);
    in_data = 32'h40;
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk($sformatf("full_ir%0d", k), {31'b0, s_ir}, 32'h0);
      chk($sformatf("full_cnt%0d", k), {27'b0, s_cnt}, 32'd16);
      chk($sformatf("full_ov%0d", k), {31'b0, s_ov}, 32'h1);
    end
    out_ready = 1'b1;
    repeat (40) cycle();
    chk("full_17th_taken", {31'b0, in_valid}, 32'h0);
    chk("full_rem_cnt", {27'b0, s_cnt}, 32'd2);
    chk("full_rem_ov", {31'b0, s_ov}, 32'h0);
    expect_beats("full", 32'h30, 15, 32'h4210);
    pulse_flush();
    repeat (10) cycle();
    expect_beats("full_tail", 32'h3F, 2, 32'h2);

    for (int i = 0; i < 5; i++) push_word(32'h20 + i);
    for (int k = 0; k < 20; k++) begin
      out_ready = (k % 2 == 0);
      cycle();
    end
    out_ready = 1'b1;
    expect_beats("bp", 32'h20, 5, 32'h10);
    chk("bp_cnt", {27'b0, s_cnt}, 32'h0);

    for (int i = 0; i < 5; i++) push_word(32'h50 + i);
    for (int k = 0; k < 40 && q_data.size() < 2; k++) cycle();
    rst_n = 1'b0;
    cycle();
    chk("midrst_ov", {31'b0, s_ov}, 32'h0);
    chk("midrst_ol", {31'b0, s_ol}, 32'h0);
    chk("midrst_ir", {31'b0, s_ir}, 32'h1);
    rst_n = 1'b1;
    cycle();
    chk("postrst_ov", {31'b0, s_ov}, 32'h0);
    chk("postrst_cnt", {27'b0, s_cnt}, 32'h0);
    expect_beats("mid", 32'h50, 2, 32'h0);
    for (int i = 0; i < 5; i++) push_word(32'h60 + i);
    repeat (15) cycle();
    expect_beats("clean", 32'h60, 5, 32'h10);
    chk("clean_cnt", {27'b0, s_cnt}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/chunk_burster.md
Name: chunk_burster

Overview:
- Stream buffer that accepts 32-bit words one at a time and emits them downstream as contiguous bursts of CHUNK words.
- The last beat of each burst is tagged out_last.
- Upstream is a random word source that pushes words in order. Downstream is a consumer that processes fixed-size windows, i.e. words i to i+CHUNK-1 for i stepping by CHUNK.
- A flush request drains any remaining partial chunk as a short burst.

Parameters:
- WIDTH, 32, data word width in bits.
- DEPTH, 16, FIFO depth in words; must be a power of two and at least CHUNK.
- CHUNK, 5, words per burst; range 1 to DEPTH.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  upstream word valid.
- in_data  input  WIDTH  upstream word.
- in_ready  output  1  high when the block can accept a word (FIFO not full).
- flush  input  1  single-cycle pulse requesting drain of a partial chunk.
- out_valid  output  1  downstream beat valid.
- out_data  output  WIDTH  downstream word (FIFO head).
- out_last  output  1  final beat of the current burst.
- out_ready  input  1  downstream accepts the beat.
- count  output  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset
  - Reset is synchronous and active-low on rst_n, single clock clk.
  - With rst_n low at a rising edge: FIFO pointers cleared, count=0, state=IDLE, flush_pending=0, beat counter=0.
  - Outputs while in reset: out_valid=0, out_last=0, in_ready=1, out_data=don't-care.
  - Reset mid-burst abandons the burst. Buffered words are discarded and no out_last is issued.
- Handshakes
  - Push occurs when in_valid && in_ready. Pop occurs when out_valid && out_ready.
  - in_ready = (count != DEPTH). There is no bypass when full: a pop in the same cycle does not raise in_ready.
  - Simultaneous push and pop leaves count unchanged. Data order is preserved, and pointers wrap modulo DEPTH.
  - out_data, out_last and out_valid stay stable while out_valid && !out_ready.
- State machine (registered)
  - IDLE: out_valid=0.
    - Move to BURST when count >= CHUNK; set burst_len=CHUNK.
    - Otherwise, if flush_pending && count > 0, move to BURST with burst_len=count.
    - If flush_pending && count == 0, clear flush_pending and stay in IDLE.
  - BURST: out_valid=1 and out_last=(beat == burst_len-1).
    - On each pop, beat increments.
    - On a pop with out_last set: beat=0 and state returns to IDLE.
    - If that burst was a flush burst (burst_len < CHUNK), flush_pending clears at the same edge.
  - burst_len is latched on entry to BURST. It only ever counts words already in the FIFO, so out_valid never drops mid-burst.
- Latency
  - Word CHUNK is accepted at edge E, so count=CHUNK after E.
  - State becomes BURST at E+1; the first out_valid is in the cycle after E+1.
  - With out_ready held high, CHUNK beats follow on consecutive cycles.
- Flush
  - A flush pulse sets flush_pending, which is sticky until served.
  - Flush arriving during BURST: the current burst completes normally. The remainder is handled from IDLE: full chunks are sent first, then the partial chunk.
  - Flush with an empty FIFO produces no output.
  - Flush in the same cycle as a push counts the pushed word.
- Widths
  - count is $clog2(DEPTH)+1 bits so that DEPTH is representable.
  - Pointers are $clog2(DEPTH) bits and wrap naturally.

Optional Feature:
- Macro: CHUNK_BURSTER_STATS_EN.
- When defined, the block adds two outputs:
  - chunks_sent (16 bits): increments on every out_last pop and saturates at 16'hFFFF.
  - partial_sent (16 bits): increments only on out_last pops of flush bursts and saturates at 16'hFFFF.
  - Both reset to 0 on rst_n low.
- When not defined, neither port nor their counters exist. All other behaviour is identical.

Test Plan:
- Reset then idle: hold rst_n=0 for 2 edges then release -> in_ready=1, out_valid=0, count=0, out_last=0.
- Push 10 words 0x1..0xA back-to-back with out_ready=1 -> two bursts: 0x1..0x5 with out_last on 0x5, then 0x6..0xA with out_last on 0xA. First out_valid occurs 2 edges after 0x5 is accepted; count returns to 0.
- Push 7 words 0x10..0x16, then pulse flush with out_ready=1 -> burst 0x10..0x14 (last on 0x14), then burst 0x15..0x16 (last on 0x16), then flush_pending clears.
- Fill with out_ready=0: push 17 words -> in_ready=0 after the 16th accept and count=16. The 17th word is held until a pop occurs; raising out_ready drains bursts in order 5,5,5, then the remaining 2 words wait for a flush.
- Backpressure: 5 words 0x20..0x24 with out_ready toggling 1,0,1,0 -> each word appears exactly once in order, out_data is stable while stalled, and out_last occurs only on 0x24.
- Assert rst_n=0 mid-burst after 2 of 5 beats -> next cycle out_valid=0 and count=0. A subsequent push of 5 words yields a clean burst.
